line_win_checker: RTL and testbench
===================================

Name: line_win_checker

Overview:
Parametrised five-in-a-row win detector. It scans the four lines through a newly placed stone: horizontal, vertical, diagonal and anti-diagonal. It reads the board memory through a 1-cycle-latency read port and counts consecutive cells of the same colour. It sits between the move pointer and the game-control FSM and reports success, the winning direction and a done pulse.

Parameters:
BOARD_W, 16, board columns (x range 0..BOARD_W-1)
BOARD_H, 16, board rows (y range 0..BOARD_H-1)
COORD_W, 4, bits per coordinate; BOARD_W and BOARD_H must each be <= 2**COORD_W
WIN_LEN, 5, run length that wins (>= 2)
CELL_W, 2, bits per board cell; value 0 = empty

Ports:
clk  in  1  clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request check; sampled only in IDLE
pointer  in  2*COORD_W  placed stone, {y, x}
chess  in  CELL_W  colour of the placed stone
rd_en  out  1  board read strobe
rd_addr  out  2*COORD_W  read address {y, x}
rd_data  in  CELL_W  cell value, valid the cycle after rd_en
busy  out  1  high from start acceptance until done
done  out  1  1-cycle pulse when the check completes
success  out  1  win found; valid with done and held until the next start
win_dir  out  2  winning direction: 0=H(+1,0), 1=V(0,+1), 2=D(+1,+1), 3=A(+1,-1); held like success

Behaviour:
- Reset: state IDLE; busy, done, success, rd_en = 0; win_dir = 0; rd_addr = 0; run counter = 0. Reset mid-scan aborts the scan with no done pulse.
- IDLE + start=1: latch pointer and chess, clear success and win_dir, set busy. Start while busy is ignored.
- Start with chess==0, x>=BOARD_W or y>=BOARD_H: go to FIN; done pulses next cycle with success=0 and no reads.
- States:
  - IDLE
  - SCAN: issue offset k each cycle and evaluate offset k-1
  - DRAIN: evaluate the last offset
  - FIN: pulse done, clear busy, go to IDLE
- Per direction (dx,dy): offsets k = -(WIN_LEN-1)..+(WIN_LEN-1). Cell = (x+k*dx, y+k*dy), computed in signed COORD_W+2 bits.
- Reads and in-board cells:
  - Off-board cell: rd_en=0 and the cell evaluates as a mismatch. The cycle is still consumed.
  - k=0: counted as a match without relying on memory, because the stone may not be written yet. The read is still issued.
- Evaluation: match means run+1, otherwise run=0. Run resets to 0 at each direction start.
- Run reaching WIN_LEN: success=1, win_dir=current direction, go to FIN immediately; remaining directions are skipped.
- Order H, V, D, A. Each direction takes 2*WIN_LEN cycles (2*WIN_LEN-1 issue + 1 drain).
- No win: done asserts 8*WIN_LEN+1 cycles after the start-sampling edge, i.e. 41 for WIN_LEN=5.
- rd_addr = {y, x} of the issued cell. It holds its last value when rd_en=0.

Optional Feature:
EXACT_LEN_EN:
- Defined (renju exact-five rule): scan offsets -WIN_LEN..+WIN_LEN, 2*WIN_LEN+2 cycles per direction, no early exit on reaching the count.
  - A run is judged when it terminates (mismatch or end of range).
  - success only if the terminated run contains offset 0 and its length == WIN_LEN exactly; overlines do not win.
  - FIN follows the judging evaluation.
- Undefined: behaviour as above (length >= WIN_LEN wins, early exit).

Decomposition:
- Package line_check_pkg:
  - direction enum DIR_H/DIR_V/DIR_D/DIR_A and the dx/dy lookup
  - FSM state enum
  - CELL_EMPTY constant
- Sub-module line_coord_gen (combinational): (pointer, dir, k) -> {y,x}, in_board.

Test Plan:
1. 16x16 board, row 7 x=3..7 = 1, pointer {7,5}, chess=1 -> done within 11 cycles, success=1, win_dir=0, D/A directions never read.
2. Row 7 x=4..7 = 1, x=8 = 2, x=3 = 0, pointer {7,7}, chess=1 -> success=0, done exactly 41 cycles after start.
3. Anti-diagonal (0,4),(1,3),(2,2),(3,1),(4,0) = 2, pointer {4,0}, chess=2 -> success=1, win_dir=3; off-board offsets produce rd_en=0.
4. Four stones in memory plus pointer cell still 0 in memory, forming a vertical five at x=9 -> success=1, win_dir=1.
5. Six in a row on row 0, pointer at the middle stone -> success=1 without EXACT_LEN_EN, success=0 with it.
6. Reset asserted at cycle 10 of a scan -> all outputs 0 next cycle, no done. start repeated while busy -> ignored, single done.

Source files
------------

// File: rtl/line_check_pkg.sv
// Shared types for the line win checker: scan directions with their unit steps,
// FSM state encoding and the empty-cell value.
package line_check_pkg;

  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_e;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_FIN} state_e;

  localparam int CELL_EMPTY = 0;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } step_t;

  function automatic step_t dir_step(dir_e d);
    step_t s;
    unique case (d)
      DIR_H:   s = '{dx: 2'sd1, dy: 2'sd0};
      DIR_V:   s = '{dx: 2'sd0, dy: 2'sd1};
      DIR_D:   s = '{dx: 2'sd1, dy: 2'sd1};
      DIR_A:   s = '{dx: 2'sd1, dy: -2'sd1};
      default: s = '{dx: 2'sd0, dy: 2'sd0};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/line_coord_gen.sv
// Combinational cell generator: stone position + direction + signed offset k
// gives the probed cell address {y, x} and whether it lies on the board.
module line_coord_gen
  import line_check_pkg::*;
#(
  parameter int COORD_W = 4,
  parameter int K_W     = 4,
  parameter int BOARD_W = 16,
  parameter int BOARD_H = 16
) (
  input  logic [2*COORD_W-1:0]  ptr,
  input  dir_e                  dir,
  input  logic signed [K_W-1:0] k,
  output logic [2*COORD_W-1:0]  addr,
  output logic                  in_board
);
  localparam int C_W = COORD_W + 2;

  // Unit steps are only -1/0/+1, so the product k*d reduces to a select.
  function automatic logic signed [C_W-1:0] offs(logic signed [1:0] d,
                                                 logic signed [C_W-1:0] kk);
    if (d[1])      return -kk;
    else if (d[0]) return kk;
    else           return '0;
  endfunction

  step_t                 st;
  logic signed [C_W-1:0] k_s, x_s, y_s;

  always_comb begin
    st  = dir_step(dir);
    k_s = C_W'(k);
    x_s = signed'(C_W'(ptr[COORD_W-1:0]))         + offs(st.dx, k_s);
    y_s = signed'(C_W'(ptr[2*COORD_W-1:COORD_W])) + offs(st.dy, k_s);
    in_board = !x_s[C_W-1] && !y_s[C_W-1] &&
               (x_s < C_W'(BOARD_W)) && (y_s < C_W'(BOARD_H));
    addr = {y_s[COORD_W-1:0], x_s[COORD_W-1:0]};
  end

endmodule

// File: rtl/line_win_checker.sv
// Five-in-a-row detector scanning H, V, D, A lines through the placed stone.
// Define EXACT_LEN_EN for the exact-length (no overline) rule.
module line_win_checker
  import line_check_pkg::*;
#(
  parameter int BOARD_W = 16,
  parameter int BOARD_H = 16,
  parameter int COORD_W = 4,
  parameter int WIN_LEN = 5,
  parameter int CELL_W  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*COORD_W-1:0] pointer,
  input  logic [CELL_W-1:0]    chess,
  output logic                 rd_en,
  output logic [2*COORD_W-1:0] rd_addr,
  input  logic [CELL_W-1:0]    rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 success,
  output logic [1:0]           win_dir
);
`ifdef EXACT_LEN_EN
  localparam int KMAX = WIN_LEN;
`else
  localparam int KMAX = WIN_LEN - 1;
`endif
  localparam int K_W   = $clog2(KMAX + 1) + 1;
  localparam int RUN_W = $clog2(2*KMAX + 2) + 1;
  localparam logic signed [K_W-1:0] K_LO = K_W'(-KMAX);
  localparam logic signed [K_W-1:0] K_HI = K_W'(KMAX);
  localparam logic [RUN_W-1:0]      WIN  = RUN_W'(WIN_LEN);

  state_e                 state_q, state_d;
  dir_e                   dir_q, dir_d;
  logic signed [K_W-1:0]  k_q, k_d;
  logic [RUN_W-1:0]       run_q, run_d, run_nx;
  logic [2*COORD_W-1:0]   ptr_q, ptr_d, rd_addr_q, rd_addr_d, issue_addr;
  logic [CELL_W-1:0]      chess_q, chess_d;
  logic                   busy_q, busy_d, done_q, done_d, success_q, success_d;
  logic [1:0]             win_dir_q, win_dir_d;
  logic                   eval_vld_q, eval_vld_d, eval_k0_q, eval_k0_d;
  logic                   eval_inb_q, eval_inb_d;
  logic                   issue_inb, match, judging, win_hit, start_bad;
`ifdef EXACT_LEN_EN
  logic                   has0_q, has0_d, has0_nx;
`endif

  line_coord_gen #(
    .COORD_W (COORD_W),
    .K_W     (K_W),
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H)
  ) u_coord (
    .ptr      (ptr_q),
    .dir      (dir_q),
    .k        (k_q),
    .addr     (issue_addr),
    .in_board (issue_inb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_H;
      k_q        <= '0;
      run_q      <= '0;
      ptr_q      <= '0;
      chess_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      success_q  <= 1'b0;
      win_dir_q  <= '0;
      rd_addr_q  <= '0;
      eval_vld_q <= 1'b0;
      eval_k0_q  <= 1'b0;
      eval_inb_q <= 1'b0;
`ifdef EXACT_LEN_EN
      has0_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      k_q        <= k_d;
      run_q      <= run_d;
      ptr_q      <= ptr_d;
      chess_q    <= chess_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      success_q  <= success_d;
      win_dir_q  <= win_dir_d;
      rd_addr_q  <= rd_addr_d;
      eval_vld_q <= eval_vld_d;
      eval_k0_q  <= eval_k0_d;
      eval_inb_q <= eval_inb_d;
`ifdef EXACT_LEN_EN
      has0_q     <= has0_d;
`endif
    end
  end

  // Offset 0 is the placed stone itself and always matches; memory may lag.
  always_comb begin
    match   = eval_inb_q && (eval_k0_q || (rd_data == chess_q));
    judging = eval_vld_q && ((state_q == ST_SCAN) || (state_q == ST_DRAIN));
    run_nx  = match ? run_q + RUN_W'(1) : '0;
`ifdef EXACT_LEN_EN
    has0_nx = match && (has0_q || eval_k0_q);
    if (match)
      win_hit = judging && (state_q == ST_DRAIN) && (run_nx == WIN) && has0_nx;
    else
      win_hit = judging && (run_q == WIN) && has0_q;
`else
    win_hit = judging && (run_nx >= WIN);
`endif
    start_bad = (chess == CELL_W'(CELL_EMPTY)) ||
                (int'(pointer[COORD_W-1:0]) >= BOARD_W) ||
                (int'(pointer[2*COORD_W-1:COORD_W]) >= BOARD_H);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = start_bad ? ST_FIN : ST_SCAN;
      ST_SCAN:  if (win_hit) state_d = ST_FIN;
                else if (k_q == K_HI) state_d = ST_DRAIN;
      ST_DRAIN: state_d = (win_hit || dir_q == DIR_A) ? ST_FIN : ST_SCAN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dir_d      = dir_q;
    k_d        = k_q;
    run_d      = run_q;
    ptr_d      = ptr_q;
    chess_d    = chess_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    success_d  = success_q;
    win_dir_d  = win_dir_q;
    rd_addr_d  = rd_addr_q;
    eval_vld_d = (state_q == ST_SCAN);
    eval_k0_d  = (k_q == '0);
    eval_inb_d = issue_inb;
`ifdef EXACT_LEN_EN
    has0_d     = has0_q;
    if (judging) has0_d = has0_nx;
`endif
    if (judging) run_d = run_nx;
    if (win_hit) begin
      success_d = 1'b1;
      win_dir_d = dir_q;
    end
    unique case (state_q)
      ST_IDLE: if (start) begin
        ptr_d     = pointer;
        chess_d   = chess;
        success_d = 1'b0;
        win_dir_d = '0;
        busy_d    = 1'b1;
        dir_d     = DIR_H;
        k_d       = K_LO;
        run_d     = '0;
`ifdef EXACT_LEN_EN
        has0_d    = 1'b0;
`endif
      end
      ST_SCAN: begin
        if (issue_inb) rd_addr_d = issue_addr;
        if (k_q != K_HI) k_d = k_q + K_W'(1);
      end
      ST_DRAIN: begin
        run_d = '0;
        dir_d = dir_e'(dir_q + 2'd1);
        k_d   = K_LO;
`ifdef EXACT_LEN_EN
        has0_d = 1'b0;
`endif
      end
      ST_FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_en   = (state_q == ST_SCAN) && issue_inb;
    rd_addr = rd_en ? issue_addr : rd_addr_q;
    busy    = busy_q;
    done    = done_q;
    success = success_q;
    win_dir = win_dir_q;
  end

endmodule

// File: tb/tb_line_win_checker.sv
// Randomized + directed bench for line_win_checker against a line-scan model.
module tb_line_win_checker;
`ifdef EXACT_LEN_EN
  localparam int KMAX = 5;
`else
  localparam int KMAX = 4;
`endif
  localparam int WL = 5;
  localparam int BW = 16;
  localparam int BH = 16;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] pointer, rd_addr;
  logic [1:0] chess, rd_data, win_dir;
  logic       rd_en, busy, done, success;
  logic [1:0] mem [256];
  int         n_chk = 0;
  int         n_err = 0;
  int         dxs [4] = '{1, 0, 1, 1};
  int         dys [4] = '{0, 1, 1, -1};

  line_win_checker #(.BOARD_W(BW), .BOARD_H(BH), .COORD_W(4), .WIN_LEN(WL), .CELL_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .pointer(pointer), .chess(chess),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .success(success), .win_dir(win_dir)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency board memory; garbage when not strobed
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 2'($urandom);

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected outcome, done latency (edges after start edge) and number of reads.
  function automatic void model(input int px, input int py, input int col,
                                output int succ, output int wdir, output int lat,
                                output int reads);
    int p, e, x, y, k, run, lo, hi, lim;
    bit ib [2*KMAX+1];
    bit m  [2*KMAX+1];
    p = 2*KMAX + 2;
    succ = 0; wdir = 0; reads = 0; lat = 4*p + 1;
    if (col == 0 || px >= BW || py >= BH) begin
      lat = 1;
      return;
    end
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 2*KMAX+1; i++) begin
        k = i - KMAX;
        x = px + k*dxs[d];
        y = py + k*dys[d];
        ib[i] = (x >= 0 && x < BW && y >= 0 && y < BH);
        m[i]  = (k == 0) || (ib[i] && int'(mem[y*BW+x]) == col);
      end
      e = -1;
`ifdef EXACT_LEN_EN
      lo = KMAX; hi = KMAX;
      while (lo > 0 && m[lo-1]) lo--;
      while (hi < 2*KMAX && m[hi+1]) hi++;
      if (hi - lo + 1 == WL) e = (hi < 2*KMAX) ? hi + 1 : 2*KMAX;
      run = 0;
`else
      lo = 0; hi = 0; run = 0;
      for (int i = 0; i < 2*KMAX+1; i++) begin
        run = m[i] ? run + 1 : 0;
        if (run >= WL && e < 0) e = i;
      end
`endif
      lim = (e >= 0) ? ((e + 1 < 2*KMAX) ? e + 1 : 2*KMAX) : 2*KMAX;
      for (int i = 0; i <= lim; i++) reads += int'(ib[i]);
      if (e >= 0) begin
        succ = 1; wdir = d; lat = d*p + e + 3;
        return;
      end
    end
  endfunction

  task automatic run_check(input string tag, input int px, input int py, input int col,
                           input int poke);
    int es, ed, el, er, c, reads, dones;
    bit seen;
    model(px, py, col, es, ed, el, er);
    @(negedge clk);
    pointer = {py[3:0], px[3:0]};
    chess   = col[1:0];
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "/busy"}, busy, 1);
    chk({tag, "/succ_clr"}, success, 0);
    c = 0; reads = 0; seen = 0;
    while (!seen && c < 300) begin
      if (rd_en) reads++;
      if (c == poke) begin
        pointer = ~pointer;
        chess   = 2'd1;
        start   = 1'b1;
      end else start = 1'b0;
      @(posedge clk); #1;
      c++;
      if (done) seen = 1;
    end
    start = 1'b0;
    chk({tag, "/done_seen"}, seen, 1);
    chk({tag, "/latency"}, c, el);
    chk({tag, "/success"}, success, es);
    chk({tag, "/win_dir"}, win_dir, ed);
    chk({tag, "/reads"}, reads, er);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      dones += int'(done);
    end
    chk({tag, "/single_done"}, dones, 0);
    chk({tag, "/succ_hold"}, success, es);
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 2'd0;
  endtask

  initial begin
    int px, py, col, d, len, sh, x, y, dones;
    reset = 1'b1; start = 1'b0; pointer = '0; chess = '0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    chk("rst/success", success, 0);
    chk("rst/rd_en", rd_en, 0);
    chk("rst/win_dir", win_dir, 0);
    chk("rst/rd_addr", rd_addr, 0);
    @(negedge clk); reset = 1'b0;

    // horizontal five, pointer in the middle
    clear_mem();
    for (int i = 3; i <= 7; i++) mem[7*16+i] = 2'd1;
    run_check("h_five", 5, 7, 1, -1);
    // four plus blocked end: no win, full scan
    clear_mem();
    for (int i = 4; i <= 7; i++) mem[7*16+i] = 2'd1;
    mem[7*16+8] = 2'd2;
    run_check("h_four", 7, 7, 1, -1);
    // anti-diagonal touching the board edge
    clear_mem();
    for (int i = 0; i <= 4; i++) mem[(4-i)*16+i] = 2'd2;
    run_check("anti", 0, 4, 2, -1);
    // vertical five with the placed stone not yet in memory
    clear_mem();
    mem[3*16+9] = 2'd1; mem[4*16+9] = 2'd1; mem[6*16+9] = 2'd1; mem[7*16+9] = 2'd1;
    run_check("vert", 9, 5, 1, -1);
    // six in a row (overline)
    clear_mem();
    for (int i = 2; i <= 7; i++) mem[i] = 2'd1;
    run_check("six", 4, 0, 1, -1);
    // empty colour: immediate done, no reads
    run_check("empty", 4, 0, 0, -1);
    // start while busy is ignored
    clear_mem();
    run_check("busy_start", 7, 7, 1, 5);

    // reset mid-scan aborts without done
    clear_mem();
    @(negedge clk);
    pointer = 8'h77; chess = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst/busy", busy, 0);
    chk("midrst/done", done, 0);
    chk("midrst/success", success, 0);
    chk("midrst/rd_en", rd_en, 0);
    chk("midrst/win_dir", win_dir, 0);
    chk("midrst/rd_addr", rd_addr, 0);
    reset = 1'b0;
    dones = 0;
    repeat (50) begin
      @(posedge clk); #1;
      dones += int'(done);
    end
    chk("midrst/no_done", dones, 0);

    for (int it = 0; it < 40; it++) begin
      foreach (mem[i]) mem[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      px  = $urandom_range(0, 15);
      py  = $urandom_range(0, 15);
      col = $urandom_range(1, 2);
      d   = $urandom_range(0, 3);
      len = $urandom_range(2, 7);
      sh  = $urandom_range(0, len - 1);
      for (int j = 0; j < len; j++) begin
        x = px + (j - sh)*dxs[d];
        y = py + (j - sh)*dys[d];
        if (x >= 0 && x < BW && y >= 0 && y < BH) mem[y*16+x] = col[1:0];
      end
      if ($urandom_range(0, 1) == 1) mem[py*16+px] = 2'd0;
      if ($urandom_range(0, 9) == 0) col = 0;
      run_check("rnd", px, py, col, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
